// File: rtl/early_exit_arbiter.sv
// Early-exit selector: serial argmax over the current exit head's dual-rail score vector.
// Accepts the first exit whose max beats its threshold, locks the deeper heads, and emits {exit_id, class} in dual rail.
module early_exit_arbiter #(
  parameter int NUM_EXITS = 2,
  parameter int NUM_CLASS = 10,
  parameter int BIT_SCORE = 16,
  parameter int BIT_W     = 32,
  parameter int ADDR_W    = 8,
  localparam int EW = (NUM_EXITS > 1) ? $clog2(NUM_EXITS) : 1,
  localparam int CW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   load,
  input  logic [ADDR_W-1:0]                      addr,
  input  logic [BIT_W-1:0]                       data_w,
  input  logic [NUM_EXITS*NUM_CLASS*BIT_SCORE-1:0] exit_t,
  input  logic [NUM_EXITS*NUM_CLASS*BIT_SCORE-1:0] exit_f,
  output logic [NUM_EXITS-1:0]                   ack_exit,
  output logic [NUM_EXITS-1:0]                   lock,
  input  logic                                   ack_nxt,
  output logic [EW+CW-1:0]                       dout_t,
  output logic [EW+CW-1:0]                       dout_f,
  output logic                                   err
);

  localparam int WORD = NUM_CLASS * BIT_SCORE;

  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, RELEASE, EMIT, WAIT_ACK, RTZ} state_t;

  state_t                       state, state_nxt;
  logic [EW-1:0]                cur;
  logic [CW-1:0]                idx;
  logic [CW-1:0]                arg;
  logic                         seen;
  logic [WORD-1:0]              vec;
  logic signed [BIT_SCORE-1:0]  max_val;
  logic [BIT_SCORE-1:0]         thr [NUM_EXITS];
  logic [1:0]                   ack_sync;

  logic [WORD-1:0]              word_t_cur, word_f_cur;
  logic                         complete, spacer, dual_high, ack_s, accept;
  logic signed [BIT_SCORE-1:0]  score;
  logic                         unused_data;

  assign unused_data = ^data_w[BIT_W-1:BIT_SCORE];

  assign word_t_cur = exit_t[int'(cur)*WORD +: WORD];
  assign word_f_cur = exit_f[int'(cur)*WORD +: WORD];
  assign complete   = &(word_t_cur ^ word_f_cur);
  assign spacer     = ~|(word_t_cur | word_f_cur);
  assign dual_high  = |(word_t_cur & word_f_cur);
  assign ack_s      = ack_sync[1];
  assign score      = vec[int'(idx)*BIT_SCORE +: BIT_SCORE];
  assign accept     = (cur == EW'(NUM_EXITS-1)) || (max_val > $signed(thr[cur]));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (complete && seen)          state_nxt = SCAN;
      SCAN:     if (idx == CW'(NUM_CLASS-1))   state_nxt = DECIDE;
      DECIDE:   state_nxt = accept ? EMIT : RELEASE;
      RELEASE:  if (spacer && seen)            state_nxt = IDLE;
      EMIT:     state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_s)                     state_nxt = RTZ;
      RTZ:      if (!ack_s && spacer)          state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur      <= '0;
      idx      <= '0;
      arg      <= '0;
      seen     <= 1'b0;
      vec      <= '0;
      max_val  <= '0;
      ack_sync <= '0;
      ack_exit <= '0;
      lock     <= '0;
      dout_t   <= '0;
      dout_f   <= '0;
      err      <= 1'b0;
      for (int k = 0; k < NUM_EXITS; k++) thr[k] <= {1'b0, {(BIT_SCORE-1){1'b1}}};
    end else begin
      ack_sync <= {ack_sync[0], ack_nxt};
      if (dual_high) err <= 1'b1;
      if (load && (addr < ADDR_W'(NUM_EXITS))) thr[addr[EW-1:0]] <= data_w[BIT_SCORE-1:0];
      seen <= 1'b0;
      case (state)
        IDLE: begin
          // two consecutive COMPLETE samples qualify the word; any gap restarts
          seen <= complete & ~seen;
          if (complete && seen) begin
            vec           <= word_t_cur;
            ack_exit[cur] <= 1'b1;
            idx           <= '0;
          end
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if ((idx == '0) || (score > max_val)) begin
            max_val <= score;
            arg     <= idx;
          end
        end
        DECIDE: begin
          if (accept)
            for (int j = 0; j < NUM_EXITS; j++) lock[j] <= (j > int'(cur));
        end
        RELEASE: begin
          seen <= spacer & ~seen;
          if (spacer && seen) begin
            ack_exit[cur] <= 1'b0;
            cur           <= cur + 1'b1;
          end
        end
        EMIT: begin
          dout_t <= {cur, arg};
          dout_f <= ~{cur, arg};
        end
        WAIT_ACK: begin
          if (ack_s) begin
            dout_t <= '0;
            dout_f <= '0;
          end
        end
        RTZ: begin
          if (!ack_s && spacer) begin
            ack_exit[cur] <= 1'b0;
            lock          <= '0;
            cur           <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
